// File: rtl/serdes_pkg.sv
// Shared definitions for the FIFO write-port arbiter: default parameters,
// FSM state encoding and a small index-width helper.
package serdes_pkg;

    localparam int DEF_N_REQ     = 4;
    localparam int DEF_WIDTH     = 8;
    localparam int DEF_MAX_BURST = 4;
    localparam int DEF_ERR_WIDTH = 8;

    // IDLE: no owner, arbitrating. BURST: one lane owns the FIFO write port.
    typedef enum logic [0:0] {
        ST_IDLE  = 1'b0,
        ST_BURST = 1'b1
    } arb_state_e;

    // Bits needed to hold a lane index; never zero so a single-lane build stays legal.
    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin lane picker: scans lanes starting one past the
// previous owner and returns the first requesting lane.
module rr_pick
    import serdes_pkg::*;
#(
    parameter int N_REQ = DEF_N_REQ,
    parameter int IDX_W = idx_width(N_REQ)
) (
    input  logic [N_REQ-1:0] req,
    input  logic [IDX_W-1:0] last_grant,
    output logic             pick_valid,
    output logic [IDX_W-1:0] pick_idx
);

    // cand_idx[k] is the lane examined at scan position k (k=0 is highest priority).
    logic [IDX_W-1:0] cand_idx [N_REQ];
    logic [N_REQ-1:0] cand_hit;

    genvar gi;
    generate
        for (gi = 0; gi < N_REQ; gi++) begin : g_cand
            assign cand_idx[gi] = IDX_W'((int'(last_grant) + gi + 1) % N_REQ);
            assign cand_hit[gi] = req[cand_idx[gi]];
        end
    endgenerate

    // Priority scan: walking from the back lets the lowest scan position win.
    always_comb begin
        pick_valid = 1'b0;
        pick_idx   = '0;
        for (int i = N_REQ - 1; i >= 0; i--) begin
            if (cand_hit[i]) begin
                pick_valid = 1'b1;
                pick_idx   = cand_idx[i];
            end
        end
    end

endmodule

// File: rtl/fifo_wr_arbiter.sv
// Burst-limited round-robin arbiter sharing one FIFO write port among
// N_REQ requesters, with a saturating FIFO write-error counter.
module fifo_wr_arbiter
    import serdes_pkg::*;
#(
    parameter int N_REQ     = DEF_N_REQ,
    parameter int WIDTH     = DEF_WIDTH,
    parameter int MAX_BURST = DEF_MAX_BURST,
    parameter int ERR_WIDTH = DEF_ERR_WIDTH
) (
    input  logic                   clk_i,
    input  logic                   rst_n_i,
    input  logic                   en_i,
    input  logic [N_REQ-1:0]       req_i,
    input  logic [N_REQ*WIDTH-1:0] data_i,
    output logic [N_REQ-1:0]       ack_o,
    output logic [N_REQ-1:0]       grant_o,
    output logic                   wr_en_o,
    output logic [WIDTH-1:0]       wdata_o,
    input  logic                   full_i,
    input  logic                   wr_error_i,
    output logic                   busy_o,
    output logic [ERR_WIDTH-1:0]   err_cnt_o
);

    localparam int IDX_W = idx_width(N_REQ);
    localparam int CNT_W = $clog2(MAX_BURST + 1);
    localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(MAX_BURST - 1);
    localparam logic [IDX_W-1:0] LAST_LANE = IDX_W'(N_REQ - 1);

    arb_state_e           state_reg, state_next;
    logic [N_REQ-1:0]     grant_reg, grant_next;
    logic [IDX_W-1:0]     owner_reg, owner_next;
    logic [IDX_W-1:0]     last_grant_reg, last_grant_next;
    logic [CNT_W-1:0]     burst_cnt_reg, burst_cnt_next;
    logic [ERR_WIDTH-1:0] err_cnt_reg, err_cnt_next;

    logic                 pick_valid;
    logic [IDX_W-1:0]     pick_idx;
    logic [WIDTH-1:0]     lane_data [N_REQ];
    logic                 in_burst;
    logic                 owner_req;
    logic                 owner_ack;

    rr_pick #(
        .N_REQ (N_REQ),
        .IDX_W (IDX_W)
    ) u_rr_pick (
        .req        (req_i),
        .last_grant (last_grant_reg),
        .pick_valid (pick_valid),
        .pick_idx   (pick_idx)
    );

    // Per-lane views of the packed data bus and per-lane acknowledge decode.
    genvar gi;
    generate
        for (gi = 0; gi < N_REQ; gi++) begin : g_lane
            assign lane_data[gi] = data_i[gi*WIDTH +: WIDTH];
            assign ack_o[gi]     = owner_ack && (owner_reg == IDX_W'(gi));
        end
    endgenerate

    // Write path is gated by reset so nothing leaks to the FIFO while held in reset.
    assign in_burst  = (state_reg == ST_BURST) && rst_n_i;
    assign owner_req = req_i[owner_reg];
    assign owner_ack = in_burst && owner_req && !full_i;

    assign wr_en_o   = owner_ack;
    assign wdata_o   = in_burst ? lane_data[owner_reg] : '0;
    assign grant_o   = grant_reg;
    assign busy_o    = (state_reg == ST_BURST);
    assign err_cnt_o = err_cnt_reg;

    // Next-state logic: grant from IDLE, count beats in BURST, release on limit or request drop.
    always_comb begin
        state_next      = state_reg;
        grant_next      = grant_reg;
        owner_next      = owner_reg;
        last_grant_next = last_grant_reg;
        burst_cnt_next  = burst_cnt_reg;
        err_cnt_next    = err_cnt_reg;

        if (wr_error_i && !(&err_cnt_reg)) begin
            err_cnt_next = err_cnt_reg + 1'b1;
        end

        case (state_reg)
            ST_IDLE: begin
                grant_next = '0;
                if (en_i && pick_valid) begin
                    state_next     = ST_BURST;
                    owner_next     = pick_idx;
                    grant_next     = N_REQ'(1) << pick_idx;
                    burst_cnt_next = '0;
                end
            end
            ST_BURST: begin
                // A full FIFO only stalls: no ack, no count, ownership kept.
                if (owner_ack) begin
                    burst_cnt_next = burst_cnt_reg + 1'b1;
                end
                if ((owner_ack && (burst_cnt_reg == LAST_BEAT)) || !owner_req) begin
                    state_next      = ST_IDLE;
                    grant_next      = '0;
                    last_grant_next = owner_reg;
                end
            end
            default: begin
                state_next = ST_IDLE;
                grant_next = '0;
            end
        endcase
    end

    // State registers; reset parks last_grant on the top lane so lane 0 wins first.
    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            state_reg      <= ST_IDLE;
            grant_reg      <= '0;
            owner_reg      <= '0;
            last_grant_reg <= LAST_LANE;
            burst_cnt_reg  <= '0;
            err_cnt_reg    <= '0;
        end else begin
            state_reg      <= state_next;
            grant_reg      <= grant_next;
            owner_reg      <= owner_next;
            last_grant_reg <= last_grant_next;
            burst_cnt_reg  <= burst_cnt_next;
            err_cnt_reg    <= err_cnt_next;
        end
    end

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Self-checking bench for fifo_wr_arbiter: a cycle-level behavioural model
// checked every cycle, plus directed scenarios with literal expectations.
module tb_fifo_wr_arbiter;

    localparam int N_REQ     = 4;
    localparam int WIDTH     = 8;
    localparam int MAX_BURST = 4;
    localparam int ERR_WIDTH = 8;
    localparam int ERR_MAX   = (1 << ERR_WIDTH) - 1;

    logic                   clk_i = 1'b0;
    logic                   rst_n_i;
    logic                   en_i;
    logic [N_REQ-1:0]       req_i;
    logic [N_REQ*WIDTH-1:0] data_i;
    logic [N_REQ-1:0]       ack_o;
    logic [N_REQ-1:0]       grant_o;
    logic                   wr_en_o;
    logic [WIDTH-1:0]       wdata_o;
    logic                   full_i;
    logic                   wr_error_i;
    logic                   busy_o;
    logic [ERR_WIDTH-1:0]   err_cnt_o;

    always #5 clk_i = ~clk_i;

    fifo_wr_arbiter #(
        .N_REQ     (N_REQ),
        .WIDTH     (WIDTH),
        .MAX_BURST (MAX_BURST),
        .ERR_WIDTH (ERR_WIDTH)
    ) dut (
        .clk_i      (clk_i),
        .rst_n_i    (rst_n_i),
        .en_i       (en_i),
        .req_i      (req_i),
        .data_i     (data_i),
        .ack_o      (ack_o),
        .grant_o    (grant_o),
        .wr_en_o    (wr_en_o),
        .wdata_o    (wdata_o),
        .full_i     (full_i),
        .wr_error_i (wr_error_i),
        .busy_o     (busy_o),
        .err_cnt_o  (err_cnt_o)
    );

    int n_checks = 0;
    int n_pass   = 0;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h at %0t", name, got, exp, $time);
    endtask

    function automatic int oh_idx(input logic [N_REQ-1:0] v);
        for (int i = 0; i < N_REQ; i++) if (v[i]) return i;
        return -1;
    endfunction

    // Behavioural model: owner lane (-1 when nobody owns), words taken, previous owner.
    int m_owner = -1;
    int m_cnt   = 0;
    int m_last  = N_REQ - 1;
    int m_err   = 0;
    bit m_valid = 1'b0;

    // Observation logs: one entry per burst.
    int lanes[$];
    int acks[$];
    int gaps[$];
    int idle_run = 0;
    logic [N_REQ-1:0] prev_grant = '0;

    always @(negedge clk_i) begin
        logic [N_REQ-1:0] e_grant;
        logic [N_REQ-1:0] e_ack;
        logic [WIDTH-1:0] e_wdata;
        e_grant = '0;
        e_ack   = '0;
        e_wdata = '0;
        if (m_owner >= 0) begin
            e_grant[m_owner] = 1'b1;
            if (rst_n_i) begin
                e_wdata = data_i[m_owner*WIDTH +: WIDTH];
                if (req_i[m_owner] && !full_i) e_ack[m_owner] = 1'b1;
            end
        end
        if (m_valid) begin
            chk("grant",  grant_o,   e_grant);
            chk("ack",    ack_o,     e_ack);
            chk("wr_en",  wr_en_o,   e_ack != '0);
            chk("wdata",  wdata_o,   e_wdata);
            chk("busy",   busy_o,    m_owner >= 0);
            chk("err_cnt", err_cnt_o, m_err);

            if (rst_n_i) begin
                if (grant_o != '0 && grant_o != prev_grant) begin
                    lanes.push_back(oh_idx(grant_o));
                    acks.push_back(0);
                    gaps.push_back(idle_run);
                    idle_run = 0;
                end
                if (grant_o == '0) idle_run++;
                if (wr_en_o && acks.size() > 0) begin
                    acks[acks.size()-1]++;
                    $display("write lane=%0d data=%02h t=%0t", oh_idx(ack_o), wdata_o, $time);
                end
            end
            prev_grant = grant_o;
        end

        // Advance the model to the state after the coming rising edge.
        if (!rst_n_i) begin
            m_owner = -1;
            m_cnt   = 0;
            m_last  = N_REQ - 1;
            m_err   = 0;
            m_valid = 1'b1;
        end else if (m_valid) begin
            if (wr_error_i && m_err < ERR_MAX) m_err++;
            if (m_owner < 0) begin
                if (en_i && req_i != '0) begin
                    for (int off = 1; off <= N_REQ; off++) begin
                        if (req_i[(m_last + off) % N_REQ]) begin
                            m_owner = (m_last + off) % N_REQ;
                            break;
                        end
                    end
                    m_cnt = 0;
                end
            end else begin
                if (e_ack != '0) m_cnt++;
                if (m_cnt == MAX_BURST || !req_i[m_owner]) begin
                    m_last  = m_owner;
                    m_owner = -1;
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic clear_logs();
        lanes.delete();
        acks.delete();
        gaps.delete();
        idle_run = 0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int exp_lanes [5];
        int wcnt;
        int n_wr;
        int n_busy;
        int more;
        int nz;

        exp_lanes = '{0, 1, 2, 3, 0};
        rst_n_i = 1'b0; en_i = 1'b1; req_i = '0; data_i = '0;
        full_i = 1'b0; wr_error_i = 1'b0;
        tick(); tick();
        rst_n_i = 1'b1;
        @(negedge clk_i);
        chk("reset_grant", grant_o, 0);
        chk("reset_busy", busy_o, 0);
        chk("reset_err", err_cnt_o, 0);
        for (int k = 0; k < N_REQ; k++) data_i[k*WIDTH +: WIDTH] = 8'(17 * (k + 1));
        tick();

        // All lanes requesting: rotation 0,1,2,3,0 with full bursts and one idle cycle between.
        clear_logs();
        req_i = 4'b1111;
        for (int c = 0; c < 60 && lanes.size() < 6; c++) tick();
        chk("rr_bursts_seen", lanes.size() >= 6, 1);
        for (int i = 0; i < 5; i++) begin
            chk("rr_lane", lanes[i], exp_lanes[i]);
            chk("rr_acks", acks[i], MAX_BURST);
            if (i > 0) chk("rr_gap", gaps[i], 1);
        end
        req_i = '0;
        repeat (3) tick();

        // Lane 2 alone with three words, then request drops.
        clear_logs();
        req_i = 4'b0100;
        data_i[2*WIDTH +: WIDTH] = 8'hC0;
        wcnt = 0;
        for (int c = 0; c < 30 && wcnt < 3; c++) begin
            @(negedge clk_i);
            if (ack_o[2]) wcnt++;
            @(posedge clk_i); #1;
            if (wcnt == 3) req_i = '0;
            else data_i[2*WIDTH +: WIDTH] = 8'(8'hC0 + wcnt);
        end
        repeat (2) tick();
        chk("solo_bursts", lanes.size(), 1);
        chk("solo_lane", lanes[0], 2);
        chk("solo_acks", acks[0], 3);
        // Previous owner was lane 2, so lane 3 must win next.
        clear_logs();
        req_i = 4'b1111;
        for (int c = 0; c < 10 && lanes.size() == 0; c++) tick();
        req_i = '0;
        chk("after_solo_lane", lanes[0], 3);
        repeat (3) tick();

        // Lane 1: two words, five full cycles, then two more words.
        clear_logs();
        req_i = 4'b0010;
        wcnt = 0;
        for (int c = 0; c < 30 && wcnt < 2; c++) begin
            @(negedge clk_i);
            if (wr_en_o) wcnt++;
            @(posedge clk_i); #1;
        end
        full_i = 1'b1;
        n_wr = 0; n_busy = 0;
        repeat (5) begin
            @(negedge clk_i);
            if (wr_en_o) n_wr++;
            if (busy_o) n_busy++;
            @(posedge clk_i); #1;
        end
        full_i = 1'b0;
        chk("stall_wr_en", n_wr, 0);
        chk("stall_busy", n_busy, 5);
        more = 0;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk_i);
            if (grant_o == '0) break;
            if (wr_en_o) more++;
            @(posedge clk_i); #1;
        end
        @(posedge clk_i); #1;
        req_i = '0;
        chk("stall_more", more, 2);
        chk("stall_lane", lanes[0], 1);
        chk("stall_total", acks[0], MAX_BURST);
        repeat (3) tick();

        // Enable drops mid-burst: burst still runs to the limit, then no new grant.
        clear_logs();
        req_i = 4'b1000;
        for (int c = 0; c < 10 && lanes.size() == 0; c++) tick();
        en_i = 1'b0;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk_i);
            if (grant_o == '0) break;
        end
        nz = 0;
        repeat (8) begin
            @(negedge clk_i);
            if (grant_o != '0) nz++;
        end
        chk("en_off_acks", acks[0], MAX_BURST);
        chk("en_off_regrants", nz, 0);
        chk("en_off_bursts", lanes.size(), 1);
        @(posedge clk_i); #1;
        req_i = '0;
        en_i = 1'b1;
        tick();

        // Error counter: one pulse, then saturation after 300 pulses.
        wr_error_i = 1'b1;
        tick();
        wr_error_i = 1'b0;
        @(negedge clk_i);
        chk("err_one", err_cnt_o, 1);
        @(posedge clk_i); #1;
        wr_error_i = 1'b1;
        repeat (300) tick();
        wr_error_i = 1'b0;
        @(negedge clk_i);
        chk("err_sat", err_cnt_o, 255);
        @(posedge clk_i); #1;

        // Reset in the middle of a burst.
        clear_logs();
        req_i = 4'b0001;
        for (int c = 0; c < 10 && lanes.size() == 0; c++) tick();
        tick();
        rst_n_i = 1'b0;
        @(negedge clk_i);
        chk("rst_hold_ack", ack_o, 0);
        chk("rst_hold_wr_en", wr_en_o, 0);
        tick();
        @(negedge clk_i);
        chk("rst_mid_grant", grant_o, 0);
        chk("rst_mid_ack", ack_o, 0);
        chk("rst_mid_err", err_cnt_o, 0);
        @(posedge clk_i); #1;
        rst_n_i = 1'b1;
        req_i = '0;
        repeat (2) tick();

        // After reset the scan starts at lane 0, so with lanes 1 and 3 asking, lane 1 wins.
        clear_logs();
        req_i = 4'b1010;
        for (int c = 0; c < 10 && lanes.size() == 0; c++) tick();
        req_i = '0;
        chk("post_rst_lane", lanes[0], 1);
        repeat (3) tick();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
